// File: rtl/registers_pkg.sv
// registers_pkg: shared datapath widths and word/select types
package registers_pkg;
  localparam int REG_WIDTH = 8;
  localparam int REG_SEL_WIDTH = 4;
  typedef logic [REG_WIDTH-1:0] reg_word_t;
  typedef logic [REG_SEL_WIDTH-1:0] reg_sel_t;
endpackage

// File: rtl/registers_reg_cell.sv
// registers_reg_cell: one W-bit register with synchronous reset and load enable
module registers_reg_cell #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_ld,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_q;
  always_ff @(posedge clk)
    if (rst) r_q <= '0;
    else if (i_ld) r_q <= i_d;
  assign o_q = r_q;
endmodule

// File: rtl/registers.sv
// registers: 2**N_b x b register file, two gated combinational reads, one clocked write
module registers
  import registers_pkg::*;
#(
  parameter int b   = REG_WIDTH,
  parameter int N_b = REG_SEL_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  output logic [b-1:0]   x,
  output logic [b-1:0]   y,
  input  logic [b-1:0]   z,
  input  logic           x_enb,
  input  logic           y_enb,
  input  logic           z_enb,
  input  logic [N_b-1:0] x_sel,
  input  logic [N_b-1:0] y_sel,
  input  logic [N_b-1:0] z_sel
);
  localparam int N = 2 ** N_b;
  logic [N-1:0] w_ld;
  logic [b-1:0] w_q [N];
  assign w_ld = {N{z_enb}} & (N'(1) << z_sel);
  for (genvar i = 0; i < N; i++) begin : g_cell
    registers_reg_cell #(.W(b)) u_cell (
      .clk  (clk),
      .rst  (rst),
      .i_ld (w_ld[i]),
      .i_d  (z),
      .o_q  (w_q[i])
    );
  end
  assign x = x_enb ? w_q[x_sel] : '0;
  assign y = y_enb ? w_q[y_sel] : '0;
endmodule

// File: tb/tb_registers.sv
// tb_registers: directed self-checking bench for the registers file
module tb_registers;
  import registers_pkg::*;
  logic clk = 0;
  logic rst = 0;
  reg_word_t x, y, z = '0;
  logic x_enb = 0, y_enb = 0, z_enb = 0;
  reg_sel_t x_sel = '0, y_sel = '0, z_sel = '0;
  int n_checks = 0;
  int n_fail = 0;

  registers dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .z(z),
    .x_enb(x_enb), .y_enb(y_enb), .z_enb(z_enb),
    .x_sel(x_sel), .y_sel(y_sel), .z_sel(z_sel)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input reg_sel_t s, input reg_word_t d);
    z = d; z_sel = s; z_enb = 1;
    tick();
    z_enb = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    tick();
    rst = 0;
    x_enb = 1; y_enb = 1;
    for (int i = 0; i < 16; i++) begin
      x_sel = reg_sel_t'(i); y_sel = reg_sel_t'(15 - i);
      #1;
      n_checks++;
      if (x !== 8'h00) begin n_fail++; $display("FAIL reset_x[%0d] got %h want 00", i, x); end
      n_checks++;
      if (y !== 8'h00) begin n_fail++; $display("FAIL reset_y[%0d] got %h want 00", 15 - i, y); end
    end
    x_enb = 0; y_enb = 0;
    #1;
    n_checks++;
    if (x !== 8'h00 || y !== 8'h00) begin n_fail++; $display("FAIL reset_disabled got x=%h y=%h want 00 00", x, y); end
  endtask

  task automatic test_basic();
    write(4'd0, 8'h01);
    write(4'd1, 8'h02);
    x_sel = 4'd0; y_sel = 4'd1; x_enb = 1; y_enb = 1;
    #1;
    n_checks++;
    if (x !== 8'h01) begin n_fail++; $display("FAIL basic_x got %h want 01", x); end
    n_checks++;
    if (y !== 8'h02) begin n_fail++; $display("FAIL basic_y got %h want 02", y); end
  endtask

  task automatic test_enable();
    x_enb = 0;
    #1;
    n_checks++;
    if (x !== 8'h00) begin n_fail++; $display("FAIL gate_x got %h want 00", x); end
    n_checks++;
    if (y !== 8'h02) begin n_fail++; $display("FAIL gate_y got %h want 02", y); end
    z = 8'hFF; z_sel = 4'd0; z_enb = 0;
    repeat (3) tick();
    x_enb = 1;
    #1;
    n_checks++;
    if (x !== 8'h01) begin n_fail++; $display("FAIL no_write_r0 got %h want 01", x); end
  endtask

  task automatic test_read_during_write();
    write(4'd3, 8'h11);
    z = 8'h22; z_sel = 4'd3; z_enb = 1; x_sel = 4'd3; x_enb = 1;
    y_sel = 4'd3; y_enb = 1;
    #1;
    n_checks++;
    if (x !== 8'h11) begin n_fail++; $display("FAIL rdw_pre got %h want 11", x); end
    tick();
    z_enb = 0;
    n_checks++;
    if (x !== 8'h22) begin n_fail++; $display("FAIL rdw_post_x got %h want 22", x); end
    n_checks++;
    if (y !== 8'h22) begin n_fail++; $display("FAIL rdw_post_y got %h want 22", y); end
  endtask

  task automatic test_reset_priority();
    write(4'd5, 8'h77);
    x_sel = 4'd5; y_sel = 4'd0; x_enb = 1; y_enb = 1;
    rst = 1; z = 8'h55; z_sel = 4'd5; z_enb = 1;
    #1;
    n_checks++;
    if (x !== 8'h77 || y !== 8'h01) begin n_fail++; $display("FAIL rst_pending got x=%h y=%h want 77 01", x, y); end
    tick();
    rst = 0; z_enb = 0;
    n_checks++;
    if (x !== 8'h00) begin n_fail++; $display("FAIL rst_priority_r5 got %h want 00", x); end
    foreach (x_sel[i]) ;
    for (int i = 0; i < 4; i++) begin
      x_sel = reg_sel_t'(i);
      #1;
      n_checks++;
      if (x !== 8'h00) begin n_fail++; $display("FAIL rst_clear_r%0d got %h want 00", i, x); end
    end
  endtask

  task automatic test_full_range();
    for (int i = 0; i < 16; i++) write(reg_sel_t'(i), reg_word_t'(i + 16));
    x_enb = 1; y_enb = 1;
    for (int i = 0; i < 16; i++) begin
      x_sel = reg_sel_t'(i); y_sel = reg_sel_t'((i + 7) % 16);
      #1;
      n_checks++;
      if (x !== reg_word_t'(i + 16)) begin n_fail++; $display("FAIL range_x[%0d] got %h want %h", i, x, i + 16); end
      n_checks++;
      if (y !== reg_word_t'((i + 7) % 16 + 16)) begin n_fail++; $display("FAIL range_y[%0d] got %h want %h", (i + 7) % 16, y, (i + 7) % 16 + 16); end
    end
    x_sel = 4'd15; y_sel = 4'd15;
    #1;
    n_checks++;
    if (x !== 8'h1F || y !== 8'h1F) begin n_fail++; $display("FAIL same_idx_15 got x=%h y=%h want 1f 1f", x, y); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_enable();
    test_read_during_write();
    test_reset_priority();
    test_full_range();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
